// File: rtl/led_pkg.sv
// led_pkg -- shared definitions for the LED shift scheduler.
//   LED_WIDTH : bits per LED word, shifted MSB first
//   state_t   : scheduler FSM encoding (IDLE / SHIFT / DONE)
//   arb_pick  : round-robin winner select for the two requesters
package led_pkg;

  localparam int LED_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Returns the winning requester index. A lone requester always wins;
  // with both requesting, prio names the requester not served last.
  function automatic logic arb_pick(input logic [1:0] req, input logic prio);
    return req[1] & (~req[0] | prio);
  endfunction

endpackage

// File: rtl/led_sclk_gen.sv
// led_sclk_gen -- serial shift-clock generator for the LED chain.
// Each bit is 2*DIV clk cycles: led_clk low for DIV cycles, then high for
// DIV cycles. All state clears while run is low, so led_clk idles low.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   run          in   high while a word is being shifted
//   led_clk      out  registered shift clock
//   shift_strobe out  one cycle before a high->low led_clk transition (bit end)
//   last_bit     out  the bit currently on the line is the final one
module led_sclk_gen
  import led_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic led_clk,
  output logic shift_strobe,
  output logic last_bit
);

  localparam int BIT_W = $clog2(LED_WIDTH);

  logic [7:0]       half_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             half_end;

  assign half_end     = run && (half_cnt == 8'(DIV - 1));
  assign shift_strobe = half_end && led_clk;
  assign last_bit     = (bit_cnt == BIT_W'(LED_WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      half_cnt <= '0;
      bit_cnt  <= '0;
      led_clk  <= 1'b0;
    end else if (!run) begin
      half_cnt <= '0;
      bit_cnt  <= '0;
      led_clk  <= 1'b0;
    end else if (half_end) begin
      half_cnt <= '0;
      led_clk  <= ~led_clk;
      // A bit ends on the falling edge; the counter wraps after the last bit.
      if (led_clk) bit_cnt <= bit_cnt + BIT_W'(1);
    end else begin
      half_cnt <= half_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/led_shift_sched.sv
// led_shift_sched -- two-requester round-robin scheduler that shifts a
// 16-bit LED word out serially (MSB first) with a divided shift clock.
// Optional feature macro: LED_REFRESH_EN -- when defined, the last
// transmitted word is retransmitted (no ack) after REFRESH_CYC consecutive
// idle cycles with no request. Ports are identical in both builds.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   req[1:0] in   level requests, held until ack
//   data0    in   requester 0 LED word
//   data1    in   requester 1 LED word
//   ack[1:0] out  one-cycle completion pulse to the granted requester
//   busy     out  high in SHIFT and DONE
//   led_clk  out  registered serial shift clock
//   led_d    out  registered serial data
module led_shift_sched
  import led_pkg::*;
#(
  parameter int DIV         = 4,
  parameter int REFRESH_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic [1:0]  ack,
  output logic        busy,
  output logic        led_clk,
  output logic        led_d
);

  state_t               state, state_nxt;
  logic [LED_WIDTH-1:0] shreg;
  logic [LED_WIDTH-1:0] data_win;
  logic [LED_WIDTH-1:0] start_word;
  logic                 req_any;
  logic                 win_id;
  logic                 prio;
  logic                 grant_id;
  logic                 start;
  logic                 run;
  logic                 shift_strobe;
  logic                 last_bit;
  logic                 refresh_due;
  logic                 is_refresh;

  assign req_any  = |req;
  assign win_id   = arb_pick(req, prio);
  assign data_win = win_id ? data1 : data0;
  assign run      = (state == ST_SHIFT);
  assign start    = (state == ST_IDLE) && (state_nxt == ST_SHIFT);
  // The line always shows the top of the shift register.
  assign led_d    = shreg[LED_WIDTH-1];

`ifdef LED_REFRESH_EN
  localparam int IDLE_W = $clog2(REFRESH_CYC + 1);

  logic [IDLE_W-1:0]    idle_cnt;
  logic [LED_WIDTH-1:0] last_word;

  // A real request always takes precedence over an expiring refresh.
  assign refresh_due = (state == ST_IDLE) && !req_any &&
                       (idle_cnt == IDLE_W'(REFRESH_CYC - 1));
  assign start_word  = req_any ? data_win : last_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt   <= '0;
      last_word  <= '0;
      is_refresh <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && !start) idle_cnt <= idle_cnt + IDLE_W'(1);
      else                              idle_cnt <= '0;
      if (start) begin
        last_word  <= start_word;
        is_refresh <= !req_any;
      end
    end
  end
`else
  localparam int unused_refresh_cyc = REFRESH_CYC;

  assign refresh_due = 1'b0;
  assign is_refresh  = 1'b0;
  assign start_word  = data_win;
`endif

  led_sclk_gen #(
    .DIV (DIV)
  ) u_sclk (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .led_clk      (led_clk),
    .shift_strobe (shift_strobe),
    .last_bit     (last_bit)
  );

  // ---- state register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_any || refresh_due)     state_nxt = ST_SHIFT;
      ST_SHIFT: if (shift_strobe && last_bit)   state_nxt = ST_DONE;
      ST_DONE:                                  state_nxt = ST_IDLE;
      default:                                  state_nxt = ST_IDLE;
    endcase
  end

  // ---- outputs ----
  always_comb begin
    busy = (state != ST_IDLE);
    ack  = 2'b00;
    if ((state == ST_DONE) && !is_refresh) ack = grant_id ? 2'b10 : 2'b01;
  end

  // ---- word capture, shifting and arbitration history ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= '0;
      grant_id <= 1'b0;
      prio     <= 1'b0;
    end else if (start) begin
      shreg <= start_word;
      // Refresh transfers leave the round-robin history untouched.
      if (req_any) begin
        grant_id <= win_id;
        prio     <= ~win_id;
      end
    end else if (shift_strobe) begin
      shreg <= {shreg[LED_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_led_shift_sched.sv
// Directed bench for led_shift_sched: one DIV=1 instance (u1) and one DIV=4
// instance (u4), each with its own reset. Monitors on the falling clock edge
// collect led_clk rises, the led_d bits seen on them, transfer start cycles
// and ack pulses; the main sequence compares them to hand-computed values.
module tb_led_shift_sched;

  logic        clk = 1'b0;
  logic        rst1, rst4;
  logic [1:0]  req1, req4, ack1, ack4;
  logic [15:0] d0_1, d1_1, d0_4, d1_4;
  logic        busy1, busy4, lclk1, lclk4, ld1, ld4;

  int cmps = 0;
  int errs = 0;
  int cyc  = 0;

  int          rises1 = 0, rises4 = 0, busyn4 = 0, ackn1 = 0, ackn4 = 0;
  int          ackcyc1 = 0, ackcyc4 = 0;
  logic [31:0] bits1 = '0, bits4 = '0;
  int          e0_1[$];
  int          e0_4[$];
  logic        pclk1 = 1'b0, pd1 = 1'b0, pbusy1 = 1'b0;
  logic        pclk4 = 1'b0, pd4 = 1'b0, pbusy4 = 1'b0;
  int          a_cyc;

  led_shift_sched #(.DIV(1), .REFRESH_CYC(100)) u1 (
    .clk(clk), .rst(rst1), .req(req1), .data0(d0_1), .data1(d1_1),
    .ack(ack1), .busy(busy1), .led_clk(lclk1), .led_d(ld1));

  led_shift_sched #(.DIV(4)) u4 (
    .clk(clk), .rst(rst4), .req(req4), .data0(d0_4), .data1(d1_4),
    .ack(ack4), .busy(busy4), .led_clk(lclk4), .led_d(ld4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (lclk1 && !pclk1) begin
      cmps++;
      assert (ld1 === pd1) else begin
        errs++;
        $error("FAIL led_d_stable_u1 observed=%0b expected=%0b", ld1, pd1);
      end
      rises1++;
      bits1 = {bits1[30:0], ld1};
    end
    if (busy1 && !pbusy1) e0_1.push_back(cyc);
    if (ack1 != 2'b00) begin
      ackn1++;
      ackcyc1 = cyc;
    end
    pclk1 = lclk1; pd1 = ld1; pbusy1 = busy1;
  end

  always @(negedge clk) begin
    if (lclk4 && !pclk4) begin
      cmps++;
      assert (ld4 === pd4) else begin
        errs++;
        $error("FAIL led_d_stable_u4 observed=%0b expected=%0b", ld4, pd4);
      end
      rises4++;
      bits4 = {bits4[30:0], ld4};
    end
    if (busy4 && !pbusy4) e0_4.push_back(cyc);
    if (busy4) busyn4++;
    if (ack4 != 2'b00) begin
      ackn4++;
      ackcyc4 = cyc;
    end
    pclk4 = lclk4; pd4 = ld4; pbusy4 = busy4;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr1();
    rises1 = 0; bits1 = '0; ackn1 = 0; ackcyc1 = 0;
    e0_1.delete();
  endtask

  task automatic wait_ack1();
    for (int i = 0; i < 100 && ack1 == 2'b00; i++) tick();
  endtask

  function automatic int q_at(input int q[$], input int idx);
    return (q.size() > idx) ? q[idx] : -1000;
  endfunction

  initial begin
    rst1 = 1'b0; rst4 = 1'b0;
    req1 = 2'b00; req4 = 2'b00;
    d0_1 = '0; d1_1 = '0; d0_4 = '0; d1_4 = '0;
    tick(); tick();
    check("reset_u1", {ack1, busy1, lclk1, ld1}, 32'h0);
    check("reset_u4", {ack4, busy4, lclk4, ld4}, 32'h0);

    // DIV=4, requester 1 alone, request dropped mid-transfer
    rst4 = 1'b1;
    tick();
    d1_4 = 16'h8001; req4 = 2'b10;
    for (int i = 0; i < 10 && !busy4; i++) tick();
    check("div4_e0_outputs", {busy4, lclk4, ld4}, 32'h5);
    tick(); tick(); tick();
    check("div4_low_half", lclk4, 32'h0);
    tick();
    check("div4_high_half", {lclk4, ld4}, 32'h3);
    tick(); tick(); tick(); tick();
    check("div4_bit14", {lclk4, ld4}, 32'h0);
    tick();
    req4 = 2'b00; d1_4 = 16'hFFFF;
    for (int i = 0; i < 300 && ack4 == 2'b00; i++) tick();
    check("div4_ack", ack4, 32'h2);
    check("div4_ack_latency", ackcyc4 - q_at(e0_4, 0), 32'd128);
    tick(); tick(); tick();
    check("div4_busy_idle", busy4, 32'h0);
    check("div4_busy_cycles", busyn4, 32'd129);
    check("div4_rises", rises4, 32'd16);
    check("div4_bits", bits4[15:0], 32'h8001);
    check("div4_ack_count", ackn4, 32'd1);

    // DIV=1, requester 0 alone, 16'hA5C3
    rst1 = 1'b1;
    tick();
    clr1();
    d0_1 = 16'hA5C3; req1 = 2'b01;
    wait_ack1();
    check("div1_ack", ack1, 32'h1);
    req1 = 2'b00;
    check("div1_ack_latency", ackcyc1 - q_at(e0_1, 0), 32'd32);
    tick(); tick();
    check("div1_rises", rises1, 32'd16);
    check("div1_bits", bits1[15:0], 32'hA5C3);
    check("div1_busy_idle", busy1, 32'h0);

    // round robin from reset with both requesting
    rst1 = 1'b0;
    tick();
    rst1 = 1'b1;
    tick();
    clr1();
    d0_1 = 16'h1111; d1_1 = 16'h2222; req1 = 2'b11;
    wait_ack1();
    check("rr_first", ack1, 32'h1);
    req1 = 2'b10;
    tick();
    wait_ack1();
    check("rr_second", ack1, 32'h2);
    req1 = 2'b00;
    check("rr_e0_spacing", q_at(e0_1, 1) - q_at(e0_1, 0), 32'd34);
    check("rr_bits", bits1, 32'h11112222);
    tick(); tick();
    req1 = 2'b11;
    wait_ack1();
    check("rr_third", ack1, 32'h1);
    req1 = 2'b00;
    tick(); tick();

    // reset during bit 7, then a fresh transfer
    clr1();
    d0_1 = 16'hFFFF; req1 = 2'b01;
    for (int i = 0; i < 100 && rises1 < 8; i++) tick();
    check("pre_reset_state", {busy1, lclk1, ld1}, 32'h7);
    rst1 = 1'b0;
    #1;
    check("reset_async_outputs", {ack1, busy1, lclk1, ld1}, 32'h0);
    req1 = 2'b00;
    tick(); tick();
    check("reset_no_ack", ackn1, 32'd0);
    rst1 = 1'b1;
    tick();
    clr1();
    d0_1 = 16'h3C5A; req1 = 2'b01;
    wait_ack1();
    check("post_reset_ack", ack1, 32'h1);
    req1 = 2'b00;
    check("post_reset_latency", ackcyc1 - q_at(e0_1, 0), 32'd32);
    tick(); tick();
    check("post_reset_rises", rises1, 32'd16);
    check("post_reset_bits", bits1[15:0], 32'h3C5A);

    // single request of 16'h00FF followed by idle
    clr1();
    d0_1 = 16'h00FF; req1 = 2'b01;
    wait_ack1();
    check("idle_req_ack", ack1, 32'h1);
    req1 = 2'b00;
    a_cyc = ackcyc1;
    clr1();
`ifdef LED_REFRESH_EN
    for (int i = 0; i < 150 && !busy1; i++) tick();
    check("refresh_start", q_at(e0_1, 0) - a_cyc, 32'd101);
    for (int i = 0; i < 100 && busy1; i++) tick();
    tick();
    check("refresh_rises", rises1, 32'd16);
    check("refresh_bits", bits1[15:0], 32'h00FF);
    check("refresh_no_ack", ackn1, 32'd0);
`else
    for (int i = 0; i < 150; i++) tick();
    check("no_refresh_start", e0_1.size(), 32'd0);
    check("no_refresh_rises", rises1, 32'd0);
    check("no_refresh_ack", ackn1, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule

// File: doc/led_shift_sched.md
LED_SHIFT_SCHED -- requirements
Module: led_shift_sched

Interface
REQ-001 The block SHALL have parameter DIV, default 4, meaning clk cycles per shift-clock half period (legal 1..255).
REQ-002 The block SHALL have parameter REFRESH_CYC, default 1000000, meaning idle clk cycles between automatic refreshes.
REQ-003 The block SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port req  input  2  per-requester transfer request, level, held until ack.
REQ-006 The block SHALL have port data0  input  16  requester 0 LED word.
REQ-007 The block SHALL have port data1  input  16  requester 1 LED word.
REQ-008 The block SHALL have port ack  output  2  one-cycle completion pulse to the granted requester.
REQ-009 The block SHALL have port busy  output  1  high while a transfer is in progress (SHIFT or DONE).
REQ-010 The block SHALL have port led_clk  output  1  registered serial shift clock to the LED chain.
REQ-011 The block SHALL have port led_d  output  1  registered serial data, MSB first.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT, DONE; IDLE->SHIFT on any request (or refresh), SHIFT->DONE after the 16th bit, DONE->IDLE unconditionally.
REQ-013 Arbitration SHALL be round-robin: a lone request wins; on simultaneous requests the requester not served last wins; after reset requester 0 has priority.
REQ-014 At the IDLE->SHIFT edge E0 the winner's data word SHALL be captured into a 16-bit shift register, led_d = bit 15, led_clk = 0, busy = 1.
REQ-015 Each bit SHALL occupy 2*DIV cycles: led_clk low for DIV cycles, then high for DIV cycles; led_d changes only on the high->low transition.
REQ-016 The block SHALL enter DONE at edge E0+32*DIV, asserting ack[winner] for exactly one cycle with led_clk = 0; busy falls at E0+32*DIV+1.
REQ-017 Minimum spacing between successive E0 edges SHALL be 32*DIV+2 cycles; a request held through DONE is granted at the first IDLE cycle.
REQ-018 Data inputs and req SHALL be ignored during SHIFT/DONE; deasserting req mid-transfer SHALL NOT abort it and ack SHALL still be issued.
REQ-019 Exactly 16 rising edges of led_clk SHALL occur per transfer; led_clk SHALL stay low in IDLE.

Reset
REQ-020 Asserting rst (low) SHALL immediately force IDLE, ack = 0, busy = 0, led_clk = 0, led_d = 0, shift register 0, priority to requester 0, counters 0.
REQ-021 Reset mid-transfer SHALL abandon the transfer without ack; first grant after release follows REQ-013.

Configuration
REQ-022 With LED_REFRESH_EN defined, the block SHALL keep the last transmitted word (reset 0) and an idle counter; after REFRESH_CYC consecutive IDLE cycles with req = 0 it SHALL retransmit that word with identical timing, busy high, and no ack.
REQ-023 A request arriving in the same cycle the refresh counter expires SHALL win; the idle counter SHALL clear on every exit from IDLE.
REQ-024 Without LED_REFRESH_EN, no last-word register or idle counter SHALL exist and the block SHALL transmit only on request; ports are identical in both builds.

Structure
REQ-025 Shared package led_pkg SHALL hold the FSM state encoding and the constant LED_WIDTH = 16.
REQ-026 The half-period/bit counting SHALL be a single sub-module led_sclk_gen (inputs run, outputs led_clk, shift_strobe, last_bit).

Verification
REQ-027 DIV=1, req=01, data0=16'hA5C3 -> ack=01 at E0+32, 16 led_clk rises, led_d sampled on rises = 1010_0101_1100_0011.
REQ-028 req=11 from reset -> requester 0 served first (ack=01), then requester 1 (ack=10), E0 spacing exactly 34 cycles at DIV=1.
REQ-029 DIV=4, req=10 dropped after 10 cycles -> transfer completes, ack=10 at E0+128, busy high 129 cycles.
REQ-030 rst low at bit 7 of a transfer -> same cycle all outputs 0, no ack; after release req=01 -> fresh full 16-bit transfer.
REQ-031 LED_REFRESH_EN, REFRESH_CYC=100, one request with 16'h00FF then idle -> retransmission of 16'h00FF begins 100 cycles after return to IDLE, ack stays 0.
REQ-032 led_d stable whenever led_clk rises, checked by assertion throughout all scenarios.
